// File: rtl/regfile_pkg.sv
// +------------------------------------------------------------------+
// | regfile_pkg : shared register-file widths and decode helper       |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  // Basic 2:4 cell; the same cell drives the read-mux select tree.
  function automatic logic [3:0] dec2to4(input logic [1:0] sel);
    dec2to4 = 4'b0001 << sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec_onehot.sv
// +------------------------------------------------------------------+
// | dec_onehot : address to one-hot decoder built from 2:4 cells      |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module dec_onehot
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  localparam int NGRP = (ADDR_W + 1) / 2;

  logic [NGRP-1:0][3:0] grp_hot;

  // Each address digit pair is predecoded; an odd top bit uses half a cell.
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    if (2 * g + 1 < ADDR_W) begin : g_pair
      assign grp_hot[g] = dec2to4(addr[2*g+1 -: 2]);
    end else begin : g_single
      assign grp_hot[g] = dec2to4({1'b0, addr[2*g]});
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    logic [NGRP-1:0] terms;
    for (genvar g = 0; g < NGRP; g++) begin : g_term
      localparam int SEL = (i >> (2 * g)) % 4;
      assign terms[g] = grp_hot[g][SEL];
    end
    assign onehot[i] = en & (&terms);
  end

  logic unused_hot;
  assign unused_hot = ^grp_hot;

endmodule

`default_nettype wire

// File: rtl/regfile_wr_decoder.sv
// +------------------------------------------------------------------+
// | regfile_wr_decoder : registered write-back request to one-hot     |
// | write enables plus read-port bypass flags.  rev 1.0               |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_wr_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                wr_en_in,
  input  logic [ADDR_W-1:0]   wr_addr_in,
  input  logic [DATA_W-1:0]   wr_data_in,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [NUM_REGS-1:0] wr_sel,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr_valid,
  output logic                fwd_a,
  output logic                fwd_b
);

  localparam logic [ADDR_W-1:0]   c_zero_addr = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]     c_num_regs  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] c_zero_mask =
      (ZERO_REG < NUM_REGS) ? (NUM_REGS'(1) << ZERO_REG) : '0;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Flush only kills the valid bit; address and data are left to hold.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = wr_en_in;
      addr_d  = wr_addr_in;
      data_d  = wr_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  logic [NUM_REGS-1:0] dec_hot;

  dec_onehot #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .en     (valid_q),
    .addr   (addr_q),
    .onehot (dec_hot)
  );

  // A write that actually lands in the array: valid, in range, not the zero register.
  logic write_live;
  assign write_live = valid_q && (addr_q != c_zero_addr) && ({1'b0, addr_q} < c_num_regs);

  assign wr_sel   = dec_hot & ~c_zero_mask;
  assign wr_data  = data_q;
  assign wr_valid = valid_q;
  assign fwd_a    = write_live && (addr_q == rd_addr_a);
  assign fwd_b    = write_live && (addr_q == rd_addr_b);

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_decoder.sv
// +------------------------------------------------------------------+
// | tb_regfile_wr_decoder : directed scoreboard bench                 |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wr_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        wr_en_in;
  logic [4:0]  wr_addr_in;
  logic [63:0] wr_data_in;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] wr_sel;
  logic [63:0] wr_data;
  logic        wr_valid;
  logic        fwd_a;
  logic        fwd_b;

  regfile_wr_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .wr_en_in   (wr_en_in),
    .wr_addr_in (wr_addr_in),
    .wr_data_in (wr_data_in),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] sel;
    logic        valid;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference state of the captured request.
  logic        m_valid = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [63:0] m_data  = '0;

  function automatic logic m_live();
    return m_valid && (m_addr != 5'd31);
  endfunction

  function automatic logic [31:0] m_sel();
    logic [31:0] one;
    one = 32'd1;
    return m_live() ? (one << m_addr) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag);
    chk({tag, "_fwd_a"}, 64'(fwd_a), 64'(m_live() && (m_addr == rd_addr_a)));
    chk({tag, "_fwd_b"}, 64'(fwd_b), 64'(m_live() && (m_addr == rd_addr_b)));
  endtask

  task automatic step(input logic en, input logic [4:0] a, input logic [63:0] d,
                      input logic st, input logic fl, input string tag);
    exp_t e;
    wr_en_in   = en;
    wr_addr_in = a;
    wr_data_in = d;
    stall      = st;
    flush      = fl;
    if (fl) begin
      m_valid = 1'b0;
    end else if (!st) begin
      m_valid = en;
      m_addr  = a;
      m_data  = d;
    end
    e.tag   = tag;
    e.sel   = m_sel();
    e.valid = m_valid;
    e.data  = m_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_sel"},   64'(wr_sel),   64'(e.sel));
    chk({e.tag, "_valid"}, 64'(wr_valid), 64'(e.valid));
    chk({e.tag, "_data"},  wr_data,       e.data);
    chk_fwd(e.tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    wr_en_in   = 1'b0;
    wr_addr_in = '0;
    wr_data_in = '0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",   64'(wr_sel),   64'd0);
    chk("rst_valid", 64'(wr_valid), 64'd0);
    chk("rst_data",  wr_data,       64'd0);
    chk_fwd("rst");
    reset = 1'b0;

    // Basic write then idle
    step(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 1'b0, "basic");
    chk("basic_sel_const", 64'(wr_sel), 64'h0000_0020);
    step(1'b0, 5'd5, 64'h0, 1'b0, 1'b0, "idle");

    // Sweep every address; 31 is the hardwired zero register
    for (int a = 0; a < 32; a++) begin
      step(1'b1, 5'(a), {32'hA5A5_0000, 32'(a)}, 1'b0, 1'b0, $sformatf("sweep%0d", a));
    end
    chk("zero_reg_valid", 64'(wr_valid), 64'd1);
    chk("zero_reg_sel",   64'(wr_sel),   64'd0);

    // Stall holds, then flush+stall kills
    step(1'b1, 5'd7, 64'h7777, 1'b0, 1'b0, "w7");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'd3, 64'h3333, 1'b1, 1'b0, $sformatf("stall%0d", k));
      chk($sformatf("stall%0d_sel_const", k), 64'(wr_sel), 64'h80);
    end
    step(1'b1, 5'd4, 64'h4444, 1'b1, 1'b1, "flush_stall");
    step(1'b1, 5'd2, 64'h2222, 1'b0, 1'b1, "flush_only");

    // Forwarding
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd9;
    step(1'b1, 5'd9, 64'h9999, 1'b0, 1'b0, "fwd9");
    chk("fwd9_both", 64'({fwd_a, fwd_b}), 64'b11);
    rd_addr_b = 5'd10;
    #1;
    chk_fwd("fwd9_b10");
    chk("fwd9_b10_const", 64'({fwd_a, fwd_b}), 64'b10);
    rd_addr_a = 5'd31;
    step(1'b1, 5'd31, 64'h3131, 1'b0, 1'b0, "fwd31");
    chk("fwd31_a_const", 64'(fwd_a), 64'd0);

    // Back-to-back writes
    rd_addr_a = 5'd2;
    rd_addr_b = 5'd3;
    step(1'b1, 5'd1, 64'h11, 1'b0, 1'b0, "b2b1");
    step(1'b1, 5'd2, 64'h22, 1'b0, 1'b0, "b2b2");
    step(1'b1, 5'd3, 64'h33, 1'b0, 1'b0, "b2b3");
    step(1'b0, 5'd0, 64'h0,  1'b0, 1'b0, "b2b_end");

    // Asynchronous reset drops a pending write before the next edge
    rd_addr_a = 5'd12;
    rd_addr_b = 5'd12;
    step(1'b1, 5'd12, 64'hC0DE, 1'b0, 1'b0, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    chk("async_rst_sel",   64'(wr_sel),   64'd0);
    chk("async_rst_valid", 64'(wr_valid), 64'd0);
    chk("async_rst_data",  wr_data,       64'd0);
    chk_fwd("async_rst");
    #1;
    reset = 1'b0;
    step(1'b0, 5'd12, 64'hC0DE, 1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
